// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Operands are accepted in IDLE and the result is held in DONE until the consumer takes it.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_opnd1,
    input  logic [DATA_WIDTH-1:0] i_opnd2,
    input  logic [2:0]            i_funct3,
    input  logic                  i_flush,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [W-1:0]    out_q, out_d;
    logic            valid_q, valid_d;

    // Operand decode for the accept edge
    logic            sgn1_en, sgn2_en, sgn1, sgn2;
    logic [W-1:0]    mag1, mag2;
    logic            div0, ovf, special;
    logic [W-1:0]    special_res;

    assign sgn1_en = ~(i_funct3[0] & (i_funct3[1] | i_funct3[2]));
    assign sgn2_en = sgn1_en & (i_funct3 != 3'b010);
    assign sgn1    = sgn1_en & i_opnd1[W-1];
    assign sgn2    = sgn2_en & i_opnd2[W-1];
    assign mag1    = sgn1 ? -i_opnd1 : i_opnd1;
    assign mag2    = sgn2 ? -i_opnd2 : i_opnd2;

    assign div0    = (i_opnd2 == '0);
    assign ovf     = ~i_funct3[0] & (i_opnd1 == {1'b1, {(W-1){1'b0}}}) & (i_opnd2 == '1);
    assign special = i_funct3[2] & (div0 | ovf);
    assign special_res = div0 ? (i_funct3[1] ? i_opnd1 : '1)
                              : (i_funct3[1] ? '0 : i_opnd1);

    // One iteration: hi/lo hold the accumulator (multiply) or remainder/quotient (divide)
    logic [W:0]      mul_sum;
    logic            rem_ge;
    logic [W-1:0]    rem_diff;
    logic [W-1:0]    hi_n, lo_n;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rem_ge   = ({hi_q, lo_q[W-1]} >= {1'b0, b_q});
    // Difference is below the divisor, so the low W bits are exact
    assign rem_diff = {hi_q[W-2:0], lo_q[W-1]} - b_q;

    always_comb begin
        hi_n = hi_q;
        lo_n = lo_q;
        if (op_q[2]) begin
            hi_n = rem_ge ? rem_diff : {hi_q[W-2:0], lo_q[W-1]};
            lo_n = {lo_q[W-2:0], rem_ge};
        end else begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    logic [2*W-1:0]  prod_s;
    logic [W-1:0]    quo_s, rem_s, result;

    assign prod_s = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    assign quo_s  = neg_q ? -lo_n : lo_n;
    assign rem_s  = neg_q ? -hi_n : hi_n;

    always_comb begin
        result = prod_s[2*W-1:W];
        if (op_q[2]) begin
            result = op_q[1] ? rem_s : quo_s;
        end else if (op_q[1:0] == 2'b00) begin
            result = prod_s[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        out_d   = out_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (i_in_valid && !i_flush) begin
                    op_d  = i_funct3;
                    neg_d = (i_funct3[2] & i_funct3[1]) ? sgn1 : (sgn1 ^ sgn2);
                    b_d   = mag2;
                    hi_d  = '0;
                    lo_d  = mag1;
                    cnt_d = CW'(W);
                    if (special) begin
                        out_d   = special_res;
                        valid_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (i_flush) begin
                    state_d = StIdle;
                end else begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        out_d   = result;
                        valid_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (i_flush || i_out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign o_in_ready  = (state_q == StIdle);
    assign o_out_valid = valid_q;
    assign o_out       = out_q;

endmodule
